uart_word_tx: RTL and testbench

- Downstream consumer of the 64-bit packet receiver's output (`uart_done` / `uart_data`).
- Buffers received 64-bit words in a small word FIFO, then serializes each word into 8 bytes on the byte-wide UART transmitter's `uart_en` / `uart_din` / `uart_tx_busy` handshake.
- Replaces the single-byte loop stage, so full 64-bit packets are echoed back.

---
 rtl/uart_word_pkg.sv | 25 ++
 rtl/uart_word_fifo.sv | 65 ++++++
 rtl/uart_word_tx.sv | 197 +++++++++++++++++++
 tb/tb_uart_word_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_word_pkg.sv
// uart_word_pkg
//   Shared constants and FSM state encoding for the 64-bit word UART
//   transmitter (uart_word_tx) and its word FIFO (uart_word_fifo).
//   No ports; imported with "import uart_word_pkg::*;".
package uart_word_pkg;

    // Serializer FSM states. ST_TERM is only reachable when the design is
    // built with UART_WORD_TERM_EN defined.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4,
        ST_TERM    = 3'd5
    } state_t;

    localparam int BYTES_PER_WORD  = 8;

    // Cycles spent in ST_WAIT_HI before giving up on the transmitter's busy
    // rising edge and moving on to ST_WAIT_LO.
    localparam int WAIT_HI_TIMEOUT = 4;
    localparam int WAIT_HI_CNT_W   = $clog2(WAIT_HI_TIMEOUT);

endpackage

// File: rtl/uart_word_fifo.sv
// uart_word_fifo
//   Parameterized synchronous FIFO with a combinational head output.
//   A push is accepted when the FIFO is not full, or when a pop happens in
//   the same cycle (occupancy unchanged). A pop on an empty FIFO is ignored.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (pointers and count to 0)
//   push   in   write din this cycle (subject to the acceptance rule)
//   pop    in   drop the head entry this cycle
//   din    in   WIDTH-bit write data
//   dout   out  WIDTH-bit head entry (valid while count != 0)
//   count  out  occupancy, 0..DEPTH
//   full   out  count == DEPTH
module uart_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx
//   Buffers 64-bit words from the packet receiver and serializes each one,
//   LSB byte first, onto a byte-wide UART transmitter.
//
//   Optional feature (macro UART_WORD_TERM_EN): after the 8th byte of each
//   word a terminator byte TERM_BYTE is sent (9 bytes per word). Without the
//   macro the terminator state, its logic and the TERM_BYTE parameter are
//   absent.
//
// Ports:
//   sys_clk     in   system clock
//   sys_rst_n   in   asynchronous active-low reset
//   recv_done   in   word-valid flag; a rising edge marks a new word
//   recv_data   in   64-bit received word, stable while recv_done is high
//   tx_busy     in   transmitter busy flag
//   send_en     out  one-cycle start pulse to the transmitter
//   send_data   out  byte to transmit, held until the next byte is loaded
//   fifo_full   out  word FIFO holds FIFO_DEPTH words
//   drop_cnt    out  words dropped on a full FIFO, saturating at 255
//   idle        out  FIFO empty and serializer FSM in ST_IDLE
//
// Transmitter handshake: send_data is loaded one cycle before the start
// pulse and held afterwards. send_en is raised for one cycle only while
// tx_busy is low; the transmitter acknowledges by raising tx_busy and frees
// the line by dropping it. A transmitter that never raises tx_busy is
// tolerated via the WAIT_HI timeout.
module uart_word_tx
    import uart_word_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
`ifdef UART_WORD_TERM_EN
    ,
    parameter logic [7:0] TERM_BYTE = 8'h0A
`endif
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        recv_done,
    input  logic [63:0] recv_data,
    input  logic        tx_busy,
    output logic        send_en,
    output logic [7:0]  send_data,
    output logic        fifo_full,
    output logic [7:0]  drop_cnt,
    output logic        idle
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_WORD - 1);
    localparam logic [WAIT_HI_CNT_W-1:0] HI_LAST = WAIT_HI_CNT_W'(WAIT_HI_TIMEOUT - 1);

    state_t                   state;
    state_t                   state_next;
    logic                     recv_done_d;
    logic                     push_req;
    logic                     fifo_pop;
    logic [63:0]              fifo_dout;
    logic [CW-1:0]            fifo_count;
    logic [63:0]              shreg;
    logic [2:0]               byte_idx;
    logic [WAIT_HI_CNT_W-1:0] hi_cnt;

    // FSM strobes towards the datapath
    logic ld_word;
    logic ld_byte;
    logic shift_byte;
    logic hi_clr;
    logic hi_inc;
`ifdef UART_WORD_TERM_EN
    logic ld_term;
    logic term_sent;   // the word's terminator byte is in flight
`endif

    assign push_req = recv_done && !recv_done_d;
    assign idle     = (fifo_count == '0) && (state == ST_IDLE);

    uart_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (recv_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        send_en    = 1'b0;
        ld_word    = 1'b0;
        ld_byte    = 1'b0;
        shift_byte = 1'b0;
        hi_clr     = 1'b0;
        hi_inc     = 1'b0;
`ifdef UART_WORD_TERM_EN
        ld_term    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (fifo_count != '0) begin
                    fifo_pop   = 1'b1;
                    ld_word    = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ld_byte    = 1'b1;
                state_next = ST_START;
            end
            ST_START: begin
                if (!tx_busy) begin
                    send_en    = 1'b1;
                    hi_clr     = 1'b1;
                    state_next = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                // Leave on busy, or after WAIT_HI_TIMEOUT cycles without it.
                if (tx_busy || (hi_cnt == HI_LAST)) state_next = ST_WAIT_LO;
                else                                hi_inc     = 1'b1;
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
`ifdef UART_WORD_TERM_EN
                    if (term_sent)                  state_next = ST_IDLE;
                    else if (byte_idx == LAST_IDX)  state_next = ST_TERM;
`else
                    if (byte_idx == LAST_IDX)       state_next = ST_IDLE;
`endif
                    else begin
                        shift_byte = 1'b1;
                        state_next = ST_LOAD;
                    end
                end
            end
`ifdef UART_WORD_TERM_EN
            ST_TERM: begin
                ld_term    = 1'b1;
                state_next = ST_START;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            recv_done_d <= 1'b0;
            shreg       <= '0;
            byte_idx    <= '0;
            send_data   <= '0;
            hi_cnt      <= '0;
            drop_cnt    <= '0;
        end else begin
            recv_done_d <= recv_done;

            if (ld_word) begin
                shreg    <= fifo_dout;
                byte_idx <= '0;
            end else if (shift_byte) begin
                shreg    <= {8'h00, shreg[63:8]};
                byte_idx <= byte_idx + 3'd1;
            end

            if (ld_byte) send_data <= shreg[7:0];
`ifdef UART_WORD_TERM_EN
            else if (ld_term) send_data <= TERM_BYTE;
`endif

            if (hi_clr)      hi_cnt <= '0;
            else if (hi_inc) hi_cnt <= hi_cnt + WAIT_HI_CNT_W'(1);

            // A push on a full FIFO survives only if IDLE pops this cycle.
            if (push_req && fifo_full && !fifo_pop && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

`ifdef UART_WORD_TERM_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                 term_sent <= 1'b0;
        else if (ld_term)               term_sent <= 1'b1;
        else if (state_next == ST_IDLE) term_sent <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx
//   Bench for uart_word_tx. A behavioural transmitter drives tx_busy with a
//   configurable latency/length, and every byte seen on send_en is matched
//   against a byte queue built from the words pushed (LSB byte first, plus
//   the terminator when UART_WORD_TERM_EN is defined). Word acceptance is
//   modelled as capacity FIFO_DEPTH + 1 (FIFO plus the word being serialized).
module tb_uart_word_tx;

    localparam int FIFO_DEPTH = 4;
`ifdef UART_WORD_TERM_EN
    localparam int BPW = 9;
`else
    localparam int BPW = 8;
`endif

    logic        sys_clk;
    logic        sys_rst_n;
    logic        recv_done;
    logic [63:0] recv_data;
    logic        tx_busy;
    logic        send_en;
    logic [7:0]  send_data;
    logic        fifo_full;
    logic [7:0]  drop_cnt;
    logic        idle;

    uart_word_tx #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .recv_done (recv_done),
        .recv_data (recv_data),
        .tx_busy   (tx_busy),
        .send_en   (send_en),
        .send_data (send_data),
        .fifo_full (fifo_full),
        .drop_cnt  (drop_cnt),
        .idle      (idle)
    );

    // ---------------- clock / cycle counter ----------------
    initial begin
        sys_clk = 1'b0;
        forever #10 sys_clk = ~sys_clk;
    end

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];
    int exp_drop = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- transmitter model ----------------
    int busy_lat   = 1;    // cycles from send_en to busy rising
    int busy_len   = 10;   // cycles busy stays high
    bit busy_never = 1'b0;
    bit force_busy = 1'b0;
    int hi_wait    = 0;
    int busy_left  = 0;
    int en_count   = 0;
    int last_en    = 0;
    int en_gap     = 0;

    always @(negedge sys_clk) begin
        logic [7:0] e;
        if (busy_left > 0) busy_left--;
        if (hi_wait > 0) begin
            hi_wait--;
            if (hi_wait == 0) busy_left = busy_len;
        end
        tx_busy = force_busy || (busy_left > 0);
        #1;
        if (send_en) begin
            check("en_while_busy", 64'(tx_busy), 64'd0);
            en_count++;
            en_gap  = cyc - last_en;
            last_en = cyc;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = 'x;
            check("send_data", 64'(send_data), 64'(e));
            if (!busy_never) hi_wait = busy_lat;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_word(input logic [63:0] w);
        int outstanding;
        @(negedge sys_clk);
        outstanding = exp_q.size() / BPW;
        recv_data = w;
        recv_done = 1'b1;
        if (outstanding < FIFO_DEPTH + 1) begin
            for (int i = 0; i < 8; i++) exp_q.push_back(w[8*i +: 8]);
`ifdef UART_WORD_TERM_EN
            exp_q.push_back(8'h0A);
`endif
        end else if (exp_drop < 255) begin
            exp_drop++;
        end
        repeat (2) @(negedge sys_clk);
        recv_done = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        repeat (3) @(negedge sys_clk);
        while (!(idle && exp_q.size() == 0 && !tx_busy) && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check({tag, "_drained"}, 64'(n < budget), 64'd1);
        check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_idle"}, 64'(idle), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_send_en"},   64'(send_en),   64'd0);
        check({tag, "_send_data"}, 64'(send_data), 64'd0);
        check({tag, "_fifo_full"}, 64'(fifo_full), 64'd0);
        check({tag, "_drop_cnt"},  64'(drop_cnt),  64'd0);
        check({tag, "_idle"},      64'(idle),      64'd1);
    endtask

    function automatic logic [63:0] rand_word();
        return {$urandom(), $urandom()};
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int en0;
        int n;
        sys_rst_n = 1'b0;
        recv_done = 1'b0;
        recv_data = '0;
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("reset");
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Single word with an ideal transmitter.
        en0 = en_count;
        push_word(64'h8877665544332211);
        wait_done("single", 3000);
        check("single_en_count", 64'(en_count - en0), 64'(BPW));

        // Burst while the transmitter is stalled: one word in the serializer,
        // four in the FIFO.
        force_busy = 1'b1;
        en0 = en_count;
        for (int i = 0; i < 5; i++) push_word(rand_word());
        check("burst_full", 64'(fifo_full), 64'((exp_q.size() / BPW) == FIFO_DEPTH + 1));
        check("burst_drop", 64'(drop_cnt), 64'(exp_drop));
        force_busy = 1'b0;
        wait_done("burst", 5000);
        check("burst_en_count", 64'(en_count - en0), 64'(5 * BPW));

        // Overflow, then drive drop_cnt into saturation.
        force_busy = 1'b1;
        en0 = en_count;
        for (int i = 0; i < 7; i++) push_word(rand_word());
        check("ovf_full", 64'(fifo_full), 64'd1);
        check("ovf_drop", 64'(drop_cnt), 64'(exp_drop));
        for (int i = 0; i < 254; i++) push_word(rand_word());
        check("ovf_drop_sat", 64'(drop_cnt), 64'(exp_drop));
        check("ovf_drop_255", 64'(exp_drop), 64'd255);
        force_busy = 1'b0;
        wait_done("ovf", 5000);
        check("ovf_en_count", 64'(en_count - en0), 64'(5 * BPW));

        // Transmitter raises busy late.
        busy_lat = 2; busy_len = 6;
        en0 = en_count;
        push_word(rand_word());
        push_word(rand_word());
        wait_done("late", 3000);
        check("late_en_count", 64'(en_count - en0), 64'(2 * BPW));

        // Transmitter never raises busy: LOAD, START, 4 WAIT_HI, WAIT_LO.
        busy_never = 1'b1;
        en0 = en_count;
        push_word(rand_word());
        wait_done("never", 3000);
        check("never_en_count", 64'(en_count - en0), 64'(BPW));
        check("never_gap", 64'(en_gap), 64'd7);
        busy_never = 1'b0;

        // Randomized traffic and transmitter timing.
        for (int p = 0; p < 8; p++) begin
            busy_never = ($urandom_range(0, 3) == 3);
            busy_lat   = $urandom_range(1, 3);
            busy_len   = $urandom_range(1, 12);
            n          = $urandom_range(1, 4);
            en0        = en_count;
            for (int i = 0; i < n; i++) begin
                push_word(rand_word());
                repeat ($urandom_range(0, 15)) @(negedge sys_clk);
            end
            wait_done("rand", 5000);
            check("rand_en_count", 64'(en_count - en0), 64'(n * BPW));
        end
        busy_never = 1'b0;
        busy_lat   = 1;
        busy_len   = 10;

        // Reset after the third byte of a word.
        en0 = en_count;
        push_word(rand_word());
        n = 0;
        while ((en_count - en0) < 3 && n < 600) begin
            @(negedge sys_clk);
            n++;
        end
        check("midrst_reach", 64'(n < 600), 64'd1);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        exp_q.delete();
        exp_drop  = 0;
        hi_wait   = 0;
        busy_left = 0;
        #2;
        check_reset_outputs("midrst");
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        en0 = en_count;
        repeat (40) @(negedge sys_clk);
        check("midrst_quiet", 64'(en_count - en0), 64'd0);
        check("midrst_idle", 64'(idle), 64'd1);
        push_word(64'h0123456789ABCDEF);
        wait_done("after_rst", 3000);
        check("after_rst_en_count", 64'(en_count - en0), 64'(BPW));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
